// File: rtl/cracker_if.sv
// cracker_if -- request/result bundle between a search controller and
// cracker_core.
//
// Signals
//   start      : one-cycle request to begin a search (controller -> core)
//   abort      : cancels a search in progress (controller -> core)
//   start_key  : first candidate key, inclusive, sampled with start
//   end_key    : last candidate key, inclusive, sampled with start
//   target     : hash value to match, sampled with start
//   busy       : core is issuing keys or draining its pipeline
//   found      : level flag, a key hashed to target
//   found_key  : the key that matched
//   exhausted  : range completed with no match
//
// Handshake: there is no ready. start is a single-cycle pulse and is
// accepted only when busy is low and abort is low. The result flags
// (found / found_key / exhausted) hold until the next accepted start.
// abort acts only while busy is high and takes priority over start.
interface cracker_if;
  logic        start;
  logic        abort;
  logic [31:0] start_key;
  logic [31:0] end_key;
  logic [31:0] target;
  logic        busy;
  logic        found;
  logic [31:0] found_key;
  logic        exhausted;

  modport master (
    output start, abort, start_key, end_key, target,
    input  busy, found, found_key, exhausted
  );

  modport slave (
    input  start, abort, start_key, end_key, target,
    output busy, found, found_key, exhausted
  );
endinterface

// File: rtl/cracker_core.sv
// cracker_core -- brute-force key search engine.
//
// Walks keys start_key..end_key one per cycle through a two-stage hash
//   stage 1: t = key ^ SALT
//   stage 2: h = rotl(t, 7) + ADD_K   (mod 2^32)
// and registers the compare of h against target one cycle later.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : cracker_if.slave request/result bundle
//   attempts  : (CRACKER_PROGRESS_EN only) saturating count of valid
//               stage-2 compares since the last accepted start
//   dbg_state : current FSM state encoding, for observation only
//
// Optional feature macro: CRACKER_PROGRESS_EN adds the attempts counter.
module cracker_core #(
  parameter logic [31:0] SALT  = 32'hA5A5A5A5,
  parameter logic [31:0] ADD_K = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        rst_n,
  cracker_if.slave    bus,
`ifdef CRACKER_PROGRESS_EN
  output logic [31:0] attempts,
`endif
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    DRAIN     = 3'd2,
    FOUND     = 3'd3,
    EXHAUSTED = 3'd4
  } state_t;

  state_t      state, state_next;

  logic [31:0] cur_key, end_q, target_q;
  logic        s1_v, s2_v;
  logic [31:0] s1_t, s1_key, s2_h, s2_key;
  logic        found_q, exhausted_q;
  logic [31:0] found_key_q;
  // An empty range is accepted from an idle state without raising busy;
  // this flag finishes it as EXHAUSTED one edge later.
  logic        empty_pend;

  logic        accept, issue, flush, take_hit, set_exh;
  logic        hit;

  assign hit = s2_v && (s2_h == target_q);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    take_hit   = 1'b0;
    set_exh    = 1'b0;
    case (state)
      IDLE, FOUND, EXHAUSTED: begin
        if (empty_pend) begin
          set_exh    = 1'b1;
          state_next = EXHAUSTED;
        end else if (bus.start && !bus.abort) begin
          accept     = 1'b1;
          state_next = (bus.start_key > bus.end_key) ? IDLE : SEARCH;
        end
      end
      SEARCH: begin
        if (bus.abort) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (hit) begin
          flush      = 1'b1;
          take_hit   = 1'b1;
          state_next = FOUND;
        end else begin
          issue = 1'b1;
          if (cur_key == end_q) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (hit) begin
          flush      = 1'b1;
          take_hit   = 1'b1;
          state_next = FOUND;
        end else if (!s1_v) begin
          // Last key's compare is happening now and missed.
          flush      = 1'b1;
          set_exh    = 1'b1;
          state_next = EXHAUSTED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, valid bits, result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      found_q     <= 1'b0;
      found_key_q <= 32'd0;
      exhausted_q <= 1'b0;
      empty_pend  <= 1'b0;
    end else begin
      state <= state_next;
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        s1_v <= issue;
        s2_v <= s1_v;
      end
      if (accept) begin
        found_q     <= 1'b0;
        found_key_q <= 32'd0;
        exhausted_q <= 1'b0;
        empty_pend  <= (bus.start_key > bus.end_key);
      end
      if (set_exh) begin
        exhausted_q <= 1'b1;
        empty_pend  <= 1'b0;
      end
      if (take_hit) begin
        found_q     <= 1'b1;
        found_key_q <= s2_key;
      end
    end
  end

  // Datapath: qualified entirely by the valid bits above, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_key  <= bus.start_key;
      end_q    <= bus.end_key;
      target_q <= bus.target;
    end else if (issue && (cur_key != end_q)) begin
      // Stops at end_key so the counter can never wrap past 32'hFFFFFFFF.
      cur_key <= cur_key + 32'd1;
    end
    s1_t   <= cur_key ^ SALT;
    s1_key <= cur_key;
    s2_h   <= {s1_t[24:0], s1_t[31:25]} + ADD_K;
    s2_key <= s1_key;
  end

`ifdef CRACKER_PROGRESS_EN
  logic count_cmp;
  assign count_cmp = s2_v && ((state == SEARCH) || (state == DRAIN)) && !bus.abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      attempts <= 32'd0;
    end else if (accept) begin
      attempts <= 32'd0;
    end else if (count_cmp && (attempts != 32'hFFFFFFFF)) begin
      attempts <= attempts + 32'd1;
    end
  end
`endif

  assign bus.busy      = (state == SEARCH) || (state == DRAIN);
  assign bus.found     = found_q;
  assign bus.found_key = found_key_q;
  assign bus.exhausted = exhausted_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_cracker_core.sv
// tb_cracker_core -- directed, table-driven bench for cracker_core.
// Expected hashes are hand-computed constants:
//   hash(0x00) = 32'h710A4C8B, hash(0x01) = 32'h710A4C0B,
//   hash(0x15) = 32'h710A520B.
module tb_cracker_core;

  logic clk;
  logic rst_n;
  logic [2:0] dbg_state;
`ifdef CRACKER_PROGRESS_EN
  logic [31:0] attempts;
`endif

  cracker_if bus_if ();

  cracker_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
`ifdef CRACKER_PROGRESS_EN
    .attempts  (attempts),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    check(name, act);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] sk;
    logic [31:0] ek;
    logic [31:0] tg;
    logic        exp_found;
    logic [31:0] exp_key;
    logic        exp_exh;
    int          exp_cyc;
    logic [31:0] exp_att;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[6];

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.start_key = 32'd0;
    bus_if.end_key = 32'd0;
    bus_if.target = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Pulse start so it is sampled at the next edge (E0), then scramble the
  // data inputs to prove they were latched.
  task automatic pulse_start(input logic [31:0] sk, input logic [31:0] ek, input logic [31:0] tg);
    @(negedge clk);
    bus_if.start_key = sk;
    bus_if.end_key   = ek;
    bus_if.target    = tg;
    bus_if.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start     = 1'b0;
    bus_if.start_key = $urandom;
    bus_if.end_key   = $urandom;
    bus_if.target    = $urandom;
  endtask

  // Waits for found or exhausted; returns the edge index after E0.
  task automatic wait_done(output int cyc, output logic saw_busy);
    cyc = 0;
    saw_busy = bus_if.busy;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      cyc = n;
      if (bus_if.busy) saw_busy = 1'b1;
      if (bus_if.found || bus_if.exhausted) break;
    end
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int   cyc;
    logic saw_busy;
    pulse_start(v.sk, v.ek, v.tg);
    expect_eq($sformatf("v%0d cleared_found", idx), 32'(bus_if.found), 32'd0);
    expect_eq($sformatf("v%0d cleared_exh", idx), 32'(bus_if.exhausted), 32'd0);
    expect_eq($sformatf("v%0d cleared_key", idx), bus_if.found_key, 32'd0);
    wait_done(cyc, saw_busy);
    expect_eq($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_cyc));
    expect_eq($sformatf("v%0d found", idx), 32'(bus_if.found), 32'(v.exp_found));
    expect_eq($sformatf("v%0d found_key", idx), bus_if.found_key, v.exp_key);
    expect_eq($sformatf("v%0d exhausted", idx), 32'(bus_if.exhausted), 32'(v.exp_exh));
    expect_eq($sformatf("v%0d busy_seen", idx), 32'(saw_busy), 32'(v.exp_busy));
`ifdef CRACKER_PROGRESS_EN
    expect_eq($sformatf("v%0d attempts", idx), attempts, v.exp_att);
`endif
    repeat (4) @(posedge clk);
    #1;
    expect_eq($sformatf("v%0d busy_after", idx), 32'(bus_if.busy), 32'd0);
    expect_eq($sformatf("v%0d found_held", idx), 32'(bus_if.found), 32'(v.exp_found));
    expect_eq($sformatf("v%0d key_held", idx), bus_if.found_key, v.exp_key);
    expect_eq($sformatf("v%0d exh_held", idx), 32'(bus_if.exhausted), 32'(v.exp_exh));
  endtask

  // ---------------- test ----------------
  initial begin
    int   cyc;
    logic saw_busy;

    vecs[0] = '{32'h0, 32'h0, 32'h710A4C8B, 1'b1, 32'h0, 1'b0, 3, 32'd1, 1'b1};
    vecs[1] = '{32'h10, 32'h20, 32'h710A520B, 1'b1, 32'h15, 1'b0, 8, 32'd6, 1'b1};
    vecs[2] = '{32'h0, 32'h3, 32'h0, 1'b0, 32'h0, 1'b1, 6, 32'd4, 1'b1};
    vecs[3] = '{32'h5, 32'h4, 32'h0, 1'b0, 32'h0, 1'b1, 1, 32'd0, 1'b0};
    // target = hash(0): a wrap past 32'hFFFFFFFF would produce a match.
    vecs[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h710A4C8B, 1'b0, 32'h0, 1'b1, 4, 32'd2, 1'b1};
    vecs[5] = '{32'h0, 32'h3, 32'h710A4C0B, 1'b1, 32'h1, 1'b0, 4, 32'd2, 1'b1};

    do_reset();
    #1;
    expect_eq("reset busy", 32'(bus_if.busy), 32'd0);
    expect_eq("reset found", 32'(bus_if.found), 32'd0);
    expect_eq("reset exhausted", 32'(bus_if.exhausted), 32'd0);
    expect_eq("reset found_key", bus_if.found_key, 32'd0);
    expect_eq("reset state", 32'(dbg_state), 32'd0);
`ifdef CRACKER_PROGRESS_EN
    expect_eq("reset attempts", attempts, 32'd0);
`endif

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

    // Abort ignored once a search has finished (state FOUND after vecs[5]).
    @(negedge clk);
    bus_if.abort = 1'b1;
    @(posedge clk);
    #1 bus_if.abort = 1'b0;
    expect_eq("abort_in_found found", 32'(bus_if.found), 32'd1);
    expect_eq("abort_in_found key", bus_if.found_key, 32'h1);

    // Abort together with start in the middle of a 100-key search.
    pulse_start(32'd0, 32'd99, 32'd0);
    @(posedge clk);
    #1;
    expect_eq("abort busy_before", 32'(bus_if.busy), 32'd1);
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    bus_if.start_key = 32'd0;
    bus_if.end_key = 32'd0;
    bus_if.target = 32'h710A4C8B;
    @(posedge clk);
    #1;
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    expect_eq("abort busy", 32'(bus_if.busy), 32'd0);
    expect_eq("abort state", 32'(dbg_state), 32'd0);
    expect_eq("abort found", 32'(bus_if.found), 32'd0);
    expect_eq("abort exhausted", 32'(bus_if.exhausted), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    expect_eq("abort quiet found", 32'(bus_if.found), 32'd0);
    expect_eq("abort quiet exh", 32'(bus_if.exhausted), 32'd0);
    run_vector(10, vecs[0]);

    // start while busy is ignored.
    pulse_start(32'h10, 32'h20, 32'h710A520B);
    @(posedge clk);
    #1;
    bus_if.start = 1'b1;
    bus_if.start_key = 32'd0;
    bus_if.end_key = 32'd0;
    bus_if.target = 32'h710A4C8B;
    @(posedge clk);
    #1 bus_if.start = 1'b0;
    wait_done(cyc, saw_busy);
    expect_eq("busy_start latency", 32'(cyc + 2), 32'd8);
    expect_eq("busy_start found", 32'(bus_if.found), 32'd1);
    expect_eq("busy_start key", bus_if.found_key, 32'h15);

    // Reset in the middle of a search leaves no result behind.
    pulse_start(32'h10, 32'h20, 32'h710A520B);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_eq("midrst busy", 32'(bus_if.busy), 32'd0);
    expect_eq("midrst found_key", bus_if.found_key, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    expect_eq("midrst found", 32'(bus_if.found), 32'd0);
    expect_eq("midrst exhausted", 32'(bus_if.exhausted), 32'd0);
    expect_eq("midrst state", 32'(dbg_state), 32'd0);
`ifdef CRACKER_PROGRESS_EN
    expect_eq("midrst attempts", attempts, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cracker_core.md
CRACKER_CORE -- requirements
Module: cracker_core

Interface
REQ-001 SHALL provide parameter SALT, default 32'hA5A5A5A5: XOR salt applied in hash stage 1.
REQ-002 SHALL provide parameter ADD_K, default 32'h9E3779B9: additive constant applied in hash stage 2.
REQ-003 SHALL provide port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL provide port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL provide port start, input, 1: one-cycle request to begin a search.
REQ-006 SHALL provide port abort, input, 1: cancels a search in progress.
REQ-007 SHALL provide port start_key, input, 32: first candidate key, inclusive; sampled with start.
REQ-008 SHALL provide port end_key, input, 32: last candidate key, inclusive; sampled with start.
REQ-009 SHALL provide port target, input, 32: hash to match; sampled with start.
REQ-010 SHALL provide port busy, output, 1: high in SEARCH or DRAIN.
REQ-011 SHALL provide port found, output, 1: level flag for a match; drives one SuccessDetector crackerN input.
REQ-012 SHALL provide port found_key, output, 32: key that produced the match.
REQ-013 SHALL provide port exhausted, output, 1: range completed with no match.

Function
REQ-014 SHALL compute the hash in two registered stages: t = key XOR SALT; h = rotl(t,7) + ADD_K, modulo 2^32.
REQ-015 SHALL implement states IDLE, SEARCH, DRAIN, FOUND, EXHAUSTED.
REQ-016 SHALL, on start sampled at edge E0 in IDLE, FOUND or EXHAUSTED, latch inputs, clear found, exhausted and found_key, and enter SEARCH.
REQ-017 SHALL issue one key per cycle: key start_key+i enters stage 1 at E(1+i) and stage 2 at E(2+i); its compare result is registered at E(3+i).
REQ-018 SHALL, after issuing end_key, enter DRAIN and issue no further keys; the key counter SHALL never wrap past 32'hFFFFFFFF.
REQ-019 SHALL, on the first stage-2 match, set found=1 and found_key=matching key, enter FOUND, and discard later in-flight keys.
REQ-020 SHALL, when DRAIN empties with no match, set exhausted=1 and enter EXHAUSTED.
REQ-021 SHALL, if start_key > end_key, go directly to EXHAUSTED at E1 with no keys hashed.
REQ-022 SHALL hold found, found_key and exhausted until the next accepted start or reset.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL, on abort in SEARCH or DRAIN, invalidate the pipeline and return to IDLE at the next edge with found=0 and exhausted=0.
REQ-025 SHALL let abort win over start when both are high together.
REQ-026 SHALL ignore abort in IDLE, FOUND or EXHAUSTED.

Reset
REQ-027 SHALL, while rst_n=0 at a rising edge, enter IDLE, invalidate the pipeline, and drive busy=0, found=0, exhausted=0, found_key=0.
REQ-028 SHALL discard any search in progress when reset occurs mid-search; no found or exhausted SHALL result from it.

Configuration
REQ-029 SHALL, with CRACKER_PROGRESS_EN defined, add output attempts[31:0]: it counts valid stage-2 compares, clears on accepted start and on reset, and saturates at 32'hFFFFFFFF.
REQ-030 SHALL, without CRACKER_PROGRESS_EN, have no attempts port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL verify single-key match: start_key=0, end_key=0, target=32'h710A4C8B -> found=1 registered at E3, found_key=0, exhausted=0, busy=0 afterwards.
REQ-032 SHALL verify mid-range match: start_key=0x10, end_key=0x20, target=hash(0x15) -> found at E(3+5), found_key=0x15; with the macro, attempts=6.
REQ-033 SHALL verify exhaustion: start_key=0, end_key=3, target=32'h00000000 -> exhausted=1 registered at E6, found=0.
REQ-034 SHALL verify an empty range: start_key=5, end_key=4 -> exhausted=1 at E1, busy never asserts.
REQ-035 SHALL verify abort: abort and start together at E2 of a 100-key search -> IDLE at E3, found=0, exhausted=0; then a new start proceeds normally.
REQ-036 SHALL verify top of range: start_key=32'hFFFFFFFE, end_key=32'hFFFFFFFF, no match -> exactly 2 compares, exhausted=1, no wrap to 0.
